// File: rtl/spike_scheduler_pkg.sv
// spike_pkg: shared constants and types for the spike hazard controller.
//   N_SPIKE      number of spikes on the level
//   CNT_W        phase counter width (MSB = lethal half, next 3 bits = frame)
//   ROW/COL      spike tile positions (left tile of the 2-wide sprite)
//   PHASE        per-spike counter value loaded at reset
//   state_e      contact FSM states
//   lowest_set() priority encoder, lowest set bit wins
package spike_pkg;

  localparam int N_SPIKE = 3;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 7;
  localparam int POS_W   = 10;
  localparam int FRAME_W = 3;
  localparam int HC_W    = 4;
  localparam int COOL_W  = 8;

  // Element i of each packed array belongs to spike i.
  localparam logic [N_SPIKE-1:0][POS_W-1:0] ROW   = {10'd29, 10'd23, 10'd12};
  localparam logic [N_SPIKE-1:0][POS_W-1:0] COL   = {10'd20, 10'd25, 10'd10};
  localparam logic [N_SPIKE-1:0][CNT_W-1:0] PHASE = {7'h00, 7'h12, 7'h28};

  typedef enum logic {
    ST_ARMED    = 1'b0,
    ST_COOLDOWN = 1'b1
  } state_e;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_SPIKE-1:0] v);
    lowest_set = '0;
    for (int i = N_SPIKE - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/spike_scheduler_phase.sv
// spike_phase: free-running phase counter for one spike.
//   frame_clk  frame-rate clock
//   rst_n      synchronous active-low reset, loads PHASE_INIT
//   run        count enable; 0 holds the counter
//   frame      animation frame, 0 during the safe half
//   harm       high during the lethal half (counter MSB)
module spike_phase
  import spike_pkg::*;
#(
  parameter logic [CNT_W-1:0] PHASE_INIT = '0
) (
  input  logic               frame_clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [FRAME_W-1:0] frame,
  output logic               harm
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Natural binary wrap gives the 127 -> 0 rollover.
  always_comb begin
    cnt_d = cnt_q;
    if (run) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge frame_clk) begin
    if (!rst_n) cnt_q <= PHASE_INIT;
    else        cnt_q <= cnt_d;
  end

  assign harm  = cnt_q[CNT_W-1];
  assign frame = harm ? cnt_q[CNT_W-2 -: FRAME_W] : '0;

endmodule

// File: rtl/spike_scheduler.sv
// spike_scheduler: animation phase and player-contact control for the
// level's spike hazards.
//   frame_clk     frame-rate clock
//   RESET_N       synchronous active-low reset
//   run           game active; 0 freezes counters and FSM
//   player_row    player tile row
//   player_col    player tile column
//   player_valid  player position meaningful
//   frame         per-spike animation frame
//   harm          per-spike lethal flag
//   hit           one-cycle damage pulse
//   hit_idx       spike that caused the most recent hit
//   invuln        high for the whole invulnerability window
//   hit_count     saturating hit count since reset
module spike_scheduler
  import spike_pkg::*;
#(
  parameter int COOLDOWN = 60
) (
  input  logic                             frame_clk,
  input  logic                             RESET_N,
  input  logic                             run,
  input  logic [POS_W-1:0]                 player_row,
  input  logic [POS_W-1:0]                 player_col,
  input  logic                             player_valid,
  output logic [N_SPIKE-1:0][FRAME_W-1:0]  frame,
  output logic [N_SPIKE-1:0]               harm,
  output logic                             hit,
  output logic [IDX_W-1:0]                 hit_idx,
  output logic                             invuln,
  output logic [HC_W-1:0]                  hit_count
);

  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN - 1);

  for (genvar g = 0; g < N_SPIKE; g++) begin : g_phase
    spike_phase #(
      .PHASE_INIT (PHASE[g])
    ) u_phase (
      .frame_clk (frame_clk),
      .rst_n     (RESET_N),
      .run       (run),
      .frame     (frame[g]),
      .harm      (harm[g])
    );
  end

  state_e              state_q, state_d;
  logic [COOL_W-1:0]   cool_cnt_q, cool_cnt_d;
  logic                hit_q, hit_d;
  logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
  logic                invuln_q, invuln_d;
  logic [HC_W-1:0]     hit_count_q, hit_count_d;
  logic [N_SPIKE-1:0]  overlap;

  // The sprite covers its anchor tile and the one to its right.
  always_comb begin
    overlap = '0;
    for (int i = 0; i < N_SPIKE; i++) begin
      overlap[i] = player_valid & harm[i] & (player_row == ROW[i]) &
                   ((player_col == COL[i]) | (player_col == COL[i] + POS_W'(1)));
    end
  end

  always_comb begin
    state_d     = state_q;
    cool_cnt_d  = cool_cnt_q;
    hit_d       = 1'b0;
    hit_idx_d   = hit_idx_q;
    invuln_d    = invuln_q;
    hit_count_d = hit_count_q;
    unique case (state_q)
      ST_ARMED: begin
        if (run && (|overlap)) begin
          state_d    = ST_COOLDOWN;
          hit_d      = 1'b1;
          hit_idx_d  = lowest_set(overlap);
          cool_cnt_d = COOL_LOAD;
          invuln_d   = 1'b1;
          if (hit_count_q != '1) hit_count_d = hit_count_q + 1'b1;
        end
      end
      ST_COOLDOWN: begin
        // Overlaps are ignored here, including on the final window cycle.
        if (run) begin
          if (cool_cnt_q == '0) begin
            state_d  = ST_ARMED;
            invuln_d = 1'b0;
          end else begin
            cool_cnt_d = cool_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_ARMED;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (!RESET_N) begin
      state_q     <= ST_ARMED;
      cool_cnt_q  <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      invuln_q    <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cool_cnt_q  <= cool_cnt_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      invuln_q    <= invuln_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign hit       = hit_q;
  assign hit_idx   = hit_idx_q;
  assign invuln    = invuln_q;
  assign hit_count = hit_count_q;

endmodule
